// File: rtl/secded_pkg.sv
// secded_pkg: shared types and constants for the SECDED decode engine.
// Holds the FSM state enum, result flag encodings and the elaboration-time
// helpers that size the codeword and place payload bits inside it.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DECODE,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] FLG_NONE = 2'b00;
  localparam logic [1:0] FLG_SGL  = 2'b01;
  localparam logic [1:0] FLG_DBL  = 2'b10;

  // Smallest Hamming parity count p with 2^p >= dw + p + 1.
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++)
      if ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Codeword position of payload bit i (1-based); payload skips every
  // power-of-two position, so data[1] lands on position 3.
  function automatic int data_pos(input int i);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int q = 3; q <= i + 33; q++)
      if (r == 0 && (q & (q - 1)) != 0) begin
        n++;
        if (n == i) r = q;
      end
    return r;
  endfunction

endpackage

// File: rtl/secded_decode.sv
// secded_decode: combinational extended-Hamming decoder.
// Produces the error flags and the payload, correcting a single-bit error.
// A double error (or an impossible syndrome) returns the payload as received.
module secded_decode
  import secded_pkg::*;
#(
  parameter  int DATA_W = 11,
  localparam int P      = calc_p(DATA_W),
  localparam int CW_W   = DATA_W + P + 1
) (
  input  logic [CW_W-1:0]   cw,
  output logic [1:0]        flags,
  output logic [DATA_W-1:0] data
);

  logic [P-1:0] syn;
  logic         par;
  logic         single;

  // Syndrome: XOR of the indices of every set bit above the overall parity.
  always_comb begin
    syn = '0;
    for (int q = 1; q < CW_W; q++)
      if (cw[q]) syn = syn ^ P'(q);
  end

  assign par = ^cw;

  // Classify; a syndrome past the codeword end cannot be a single error.
  always_comb begin
    flags  = FLG_NONE;
    single = 1'b0;
    if (par) begin
      if (32'(syn) < CW_W) begin
        flags  = FLG_SGL;
        single = 1'b1;
      end else begin
        flags  = FLG_DBL;
      end
    end else if (syn != '0) begin
      flags = FLG_DBL;
    end
  end

  // Pull payload bits out, flipping the one the syndrome points at.
  // syn == 0 with a single error means only p0 was hit: payload untouched.
  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    localparam int POS = data_pos(i + 1);
    assign data[i] = cw[POS] ^ (single && (syn == P'(POS)));
  end

endmodule

// File: rtl/secded_dec_engine.sv
// secded_dec_engine: reads NUM_WORDS SECDED codewords from byte memory,
// decodes each and writes {flags, pad, data} results back, then raises done.
// Optional macro SECDED_STATS_EN adds single/double error counters
// (sgl_cnt, dbl_cnt).
module secded_dec_engine
  import secded_pkg::*;
#(
  parameter int DATA_W    = 11,
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
`ifdef SECDED_STATS_EN
  ,
  output logic [$clog2(NUM_WORDS+1)-1:0] sgl_cnt,
  output logic [$clog2(NUM_WORDS+1)-1:0] dbl_cnt
`endif
);

  localparam int P         = calc_p(DATA_W);
  localparam int CW_W      = DATA_W + P + 1;
  localparam int CW_BYTES  = (CW_W + 7) / 8;
  localparam int OUT_BYTES = (DATA_W + 2 + 7) / 8;
  localparam int OUT_W     = OUT_BYTES * 8;
  localparam int MAXB      = (CW_BYTES > OUT_BYTES) ? CW_BYTES : OUT_BYTES;
  localparam int BCW       = $clog2(MAXB + 1);
  localparam int WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t                       state, nxt;
  logic [BCW-1:0]               bcnt;
  logic [WCW-1:0]               wcnt;
  logic [CW_BYTES-1:0][7:0]     cw_q;
  logic [OUT_BYTES-1:0][7:0]    res_q;
  logic [CW_BYTES*8-1:0]        cw_flat;
  logic [OUT_W-1:0]             res_next;
  logic [1:0]                   dec_flags;
  logic [DATA_W-1:0]            dec_data;
  logic                         rd_last, wr_last, word_last, start;
  logic [ADDR_W-1:0]            rd_addr, wr_addr;
  logic [7:0]                   wr_byte;

  assign rd_last   = (bcnt == BCW'(CW_BYTES));
  assign wr_last   = (bcnt == BCW'(OUT_BYTES - 1));
  assign word_last = (wcnt == WCW'(NUM_WORDS - 1));
  assign start     = req && (state == IDLE || state == DONE);

  // Address arithmetic is done at ADDR_W bits so it wraps naturally.
  assign rd_addr = ADDR_W'(SRC_BASE) + ADDR_W'(CW_BYTES) * ADDR_W'(wcnt) + ADDR_W'(bcnt);
  assign wr_addr = ADDR_W'(DST_BASE) + ADDR_W'(OUT_BYTES) * ADDR_W'(wcnt) + ADDR_W'(bcnt);

  assign cw_flat = cw_q;

  secded_decode #(.DATA_W(DATA_W)) u_dec (
    .cw    (cw_flat[CW_W-1:0]),
    .flags (dec_flags),
    .data  (dec_data)
  );

  // Result word: flags in the top two bits, payload at the bottom, zero pad.
  always_comb begin
    res_next                = '0;
    res_next[DATA_W-1:0]    = dec_data;
    res_next[OUT_W-1 -: 2]  = dec_flags;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic; req only matters when not busy.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = READ;
      READ:    if (rd_last) nxt = DECODE;
      DECODE:  nxt = WRITE;
      WRITE:   if (wr_last) nxt = word_last ? DONE : READ;
      DONE:    if (req) nxt = READ;
      default: nxt = IDLE;
    endcase
  end

  // Byte/word sequencing, codeword capture, result register and done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt  <= '0;
      wcnt  <= '0;
      cw_q  <= '0;
      res_q <= '0;
      done  <= 1'b0;
    end else begin
      if ((state == READ || state == WRITE) && nxt == state) bcnt <= bcnt + 1'b1;
      else                                                   bcnt <= '0;

      if (start)                                         wcnt <= '0;
      else if (state == WRITE && wr_last && !word_last)  wcnt <= wcnt + 1'b1;

      // Read data trails the address by one cycle: byte k lands on cycle k+1.
      if (state == READ)
        for (int b = 0; b < CW_BYTES; b++)
          if (bcnt == BCW'(b + 1)) cw_q[b] <= mem_rd_data;

      if (state == DECODE) res_q <= res_next;

      // Registered one cycle behind DONE; an accepted restart drops it at once.
      done <= (state == DONE) && !req;
    end
  end

  // Select the result byte for the current write cycle.
  always_comb begin
    wr_byte = '0;
    for (int b = 0; b < OUT_BYTES; b++)
      if (bcnt == BCW'(b)) wr_byte = res_q[b];
  end

  // Memory port outputs, decoded from state so reset clears them immediately.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      READ:  mem_addr = rd_addr;
      WRITE: begin
        mem_addr    = wr_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = wr_byte;
      end
      default: ;
    endcase
  end

`ifdef SECDED_STATS_EN
  localparam int SCW = $clog2(NUM_WORDS + 1);

  // Error statistics: cleared on reset and on every accepted req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (start) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (state == DECODE) begin
      if (dec_flags == FLG_SGL) sgl_cnt <= sgl_cnt + SCW'(1);
      if (dec_flags[1])         dbl_cnt <= dbl_cnt + SCW'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_secded_dec_engine.sv
// tb_secded_dec_engine: directed checks of the SECDED decode engine with a
// byte memory model, an independent encoder and a per-word result scoreboard.
module tb_secded_dec_engine;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int DPOS [0:10] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
`ifdef SECDED_STATS_EN
  logic [3:0] sgl_cnt, dbl_cnt;
`endif

  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        load = 1'b0;
  int          wr_cnt = 0;

  logic [15:0] exp_res [NW];
  int          exp_sgl, exp_dbl;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  secded_dec_engine dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
`ifdef SECDED_STATS_EN
    ,
    .sgl_cnt     (sgl_cnt),
    .dbl_cnt     (dbl_cnt)
`endif
  );

  // Synchronous-read byte memory; load copies the prepared image in.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt        <= wr_cnt + 1;
    end
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    c = '0;
    for (int j = 0; j < 11; j++) c[DPOS[j]] = d[j];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int q = 1; q < 16; q++)
        if ((q & (1 << k)) != 0 && q != (1 << k)) p = p ^ c[q];
      c[1 << k] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] raw(input logic [15:0] c);
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = c[DPOS[j]];
    return d;
  endfunction

  // Directed words 0..3, then words with 0/1/2 injected errors.
  task automatic build_image();
    logic [10:0] d;
    logic [15:0] c;
    int          b1, b2;
    for (int i = 0; i < 256; i++) img[i] = 8'hAA;
    img[SRC+0] = 8'hFF; img[SRC+1] = 8'hFF; exp_res[0] = 16'h07FF;
    img[SRC+2] = 8'h20; img[SRC+3] = 8'h00; exp_res[1] = 16'h4000;
    img[SRC+4] = 8'hFE; img[SRC+5] = 8'hFF; exp_res[2] = 16'h47FF;
    img[SRC+6] = 8'h08; img[SRC+7] = 8'h02; exp_res[3] = 16'h8011;
    exp_sgl = 2;
    exp_dbl = 1;
    for (int i = 4; i < NW; i++) begin
      d = 11'($urandom_range(0, 2047));
      c = enc(d);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      case (i % 3)
        0: exp_res[i] = {2'b00, 3'b000, d};
        1: begin
          c[b1] = ~c[b1];
          exp_res[i] = {2'b01, 3'b000, d};
          exp_sgl++;
        end
        default: begin
          c[b1] = ~c[b1];
          c[b2] = ~c[b2];
          exp_res[i] = {2'b10, 3'b000, raw(c)};
          exp_dbl++;
        end
      endcase
      img[SRC+2*i]   = c[7:0];
      img[SRC+2*i+1] = c[15:8];
    end
  endtask

  task automatic do_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Pulse req, then count edges until done is seen (bounded).
  task automatic run(input bit mid_req, output int lat);
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    @(negedge clk); req = 1'b0;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (done) break;
      @(negedge clk); req = mid_req && (lat == 20 || lat == 50);
    end
    req = 1'b0;
  endtask

  task automatic check_results(input string pfx);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_w%0d", pfx, i), {mem[DST+2*i+1], mem[DST+2*i]}, exp_res[i]);
`ifdef SECDED_STATS_EN
    chk({pfx, "_sgl_cnt"}, sgl_cnt, exp_sgl);
    chk({pfx, "_dbl_cnt"}, dbl_cnt, exp_dbl);
`endif
  endtask

  initial begin
    int  lat;
    int  wr0;
    bit  seen;
    build_image();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
`ifdef SECDED_STATS_EN
    chk("rst_sgl_cnt", sgl_cnt, 0);
`endif
    reset = 1'b1;
    do_load();

    // Run 1: full pass with ignored mid-run req pulses.
    run(1'b1, lat);
    chk("run1_done_lat", lat, 91);
    check_results("run1");
    repeat (3) @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_wr_en", mem_wr_en, 0);

    // Run 2: restart from DONE, then reset during word 7 WRITE.
    do_load();
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1;
    chk("done_drop", done, 0);
    @(negedge clk); req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (mem_wr_en && mem_addr == 8'(DST + 14)) seen = 1'b1;
    end
    chk("w7_write_seen", seen, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_en", mem_wr_en, 0);
    chk("mid_rst_addr", mem_addr, 0);
    @(negedge clk); reset = 1'b1;

    // Run 3: from IDLE, everything reprocessed from SRC_BASE.
    do_load();
    wr0 = wr_cnt;
    run(1'b0, lat);
    chk("run3_done_lat", lat, 91);
    check_results("run3");
    chk("run3_wr_count", wr_cnt - wr0, 2 * NW);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/secded_dec_engine.md
Name: secded_dec_engine

Overview:
- Parametrised hardware successor to the software SECDED decode program.
- Reads NUM_WORDS extended-Hamming codewords from byte-wide data memory, detects errors, corrects single-bit errors and flags double-bit errors.
- Writes the flagged data words back to memory, then raises done.
- Sits beside the core on the data-memory port; started by a req pulse.

Parameters:
- DATA_W, 11, payload bits per codeword.
- NUM_WORDS, 15, codewords processed per req.
- SRC_BASE, 30, byte address of first codeword.
- DST_BASE, 0, byte address of first result.
- ADDR_W, 8, memory byte-address width.
- Derived (localparam):
  - P = smallest p with 2^p >= DATA_W+p+1.
  - CW_W = DATA_W+P+1.
  - CW_BYTES = ceil(CW_W/8).
  - OUT_BYTES = ceil((DATA_W+2)/8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start pulse, sampled in IDLE or DONE.
- done  out  1  high when all NUM_WORDS results are written.
- mem_addr  out  ADDR_W  shared byte address.
- mem_rd_data  in  8  read data, valid one cycle after mem_addr.
- mem_wr_en  out  1  byte write strobe.
- mem_wr_data  out  8  write byte.

Behaviour:
- Reset (reset=0, async): state IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, word counter=0.
- Codeword layout:
  - Bit 0 is overall parity.
  - Positions 2^k hold Hamming parity.
  - Data bits fill the remaining positions ascending, data[1] at position 3.
  - Codeword word i occupies bytes SRC_BASE+CW_BYTES*i upward, little-endian.
- Decode:
  - syn = XOR of indices of all set bits 1..CW_W-1.
  - par = XOR of all CW_W bits.
  - par=0, syn=0: flags 00, data as received.
  - par=1, syn<CW_W: flags 01, flip bit syn (syn=0 means p0 only), extract data.
  - par=0, syn!=0: flags 10, data raw/uncorrected.
  - par=1, syn>=CW_W (non-power-of-2 lengths): flags 10.
- Result: {flags[1:0], zero pad, data[DATA_W:1]}, OUT_BYTES*8 wide, little-endian at DST_BASE+OUT_BYTES*i.
- FSM states and transitions:
  - IDLE: req=1 goes to READ.
  - READ: CW_BYTES+1 cycles; address byte k on cycle k, capture mem_rd_data on cycle k+1. Goes to DECODE.
  - DECODE: 1 cycle, registers result. Goes to WRITE.
  - WRITE: OUT_BYTES cycles, mem_wr_en=1, low byte first. If last word, goes to DONE; else increments counter and goes to READ.
  - DONE: done=1, held until reset or req. req in DONE restarts at word 0, and done drops on the next edge.
- Cycles per word = CW_BYTES+OUT_BYTES+2 (defaults: 6). done rises NUM_WORDS*6+1 = 91 cycles after the req edge.
- req while busy (READ/DECODE/WRITE) is ignored.
- mem_wr_en is low in every state except WRITE.
- Reads and writes never overlap, so SRC and DST regions may share the port.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro SECDED_STATS_EN.
- Defined:
  - Adds outputs sgl_cnt and dbl_cnt, each $clog2(NUM_WORDS+1) wide.
  - Increment in DECODE on flags 01 and 1x respectively.
  - Cleared by reset and by an accepted req.
  - Held stable in DONE.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package secded_pkg holds:
  - state enum (IDLE, READ, DECODE, WRITE, DONE);
  - flag constants FLG_NONE=2'b00, FLG_SGL=2'b01, FLG_DBL=2'b10;
  - constant function for P.
- Sub-module secded_decode: purely combinational, codeword in, {flags, data} out, parametrised by DATA_W.
- The engine holds the FSM, counters, byte assembly and memory sequencing.

Test Plan:
- Data 11'h7FF, clean codeword 16'hFFFF -> result bytes low 0xFF, high 0x07; flags 00.
- Data 11'h000, bit 5 flipped (bytes 0x20, 0x00) -> result 0x00, 0x40; sgl_cnt=1 when SECDED_STATS_EN is defined.
- Data 11'h7FF with p0 flipped (0xFE, 0xFF) -> result 0xFF, 0x47; flags 01, data intact.
- Data 11'h000, bits 3 and 9 flipped (0x08, 0x02) -> result 0x11, 0x80; MSB=1.
- Full 15-word random run, one req -> done rises exactly 91 cycles after the req edge; all results match a scoreboard model; req pulsed mid-run is ignored.
- reset driven low during word 7 WRITE -> done=0 and mem_wr_en=0 immediately; new req reprocesses all 15 words from SRC_BASE.
